// File: rtl/interrupt_controller_if.sv
// CPU-side interrupt handshake bundle: request lines, mask/enable, ACK/DONE and
// the controller's request, vector, pending and busy indications.
interface interrupt_controller_if #(
    parameter int unsigned NUM_SRC   = 8,
    parameter int unsigned VEC_WIDTH = $clog2(NUM_SRC)
);
    logic [NUM_SRC-1:0]   irq;
    logic [NUM_SRC-1:0]   mask;
    logic                 int_en;
    logic                 int_ack;
    logic                 int_done;
    logic                 intr;
    logic [VEC_WIDTH-1:0] vector;
    logic [NUM_SRC-1:0]   pending;
    logic                 busy;

    modport master (
        output irq, mask, int_en, int_ack, int_done,
        input  intr, vector, pending, busy
    );

    modport slave (
        input  irq, mask, int_en, int_ack, int_done,
        output intr, vector, pending, busy
    );
endinterface

// File: rtl/interrupt_controller.sv
// Non-nesting prioritised interrupt controller: synchronises request lines,
// latches rising edges as pending bits and runs the CPU REQ/ACK/DONE handshake.
module interrupt_controller #(
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    interrupt_controller_if.slave  bus
);
    localparam int unsigned VEC_WIDTH = $clog2(NUM_SRC);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

    state_e               state_q;
    logic                 intr_q;
    logic                 busy_q;
    logic [VEC_WIDTH-1:0] vector_q;
    logic [NUM_SRC-1:0]   pending_q;
    logic [NUM_SRC-1:0]   pending_d;
    logic [NUM_SRC-1:0]   sync_q [SYNC_STAGES];
    logic [NUM_SRC-1:0]   prev_q;
    logic [NUM_SRC-1:0]   irq_rise;
    logic [NUM_SRC-1:0]   ack_clr;
    logic [NUM_SRC-1:0]   eligible;
    logic [VEC_WIDTH-1:0] winner;
    logic                 ack_taken;

    // Synchroniser chain plus previous-value register for edge detection.
    // prev resets to 0, so a line high at reset release reads as one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= bus.irq;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign irq_rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign ack_taken = (state_q == REQ) && bus.int_ack;
    assign ack_clr   = ack_taken ? (NUM_SRC'(1) << vector_q) : '0;
    assign eligible  = pending_q & bus.mask;

    // Set wins over clear so an edge coinciding with its own ACK is kept.
    always_comb begin
        pending_d = (pending_q & ~ack_clr) | irq_rise;
    end

    // Lowest eligible index wins.
    always_comb begin
        winner = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = VEC_WIDTH'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Handshake FSM; VECTOR only changes on IDLE->REQ so it stays stable
    // through the request and the whole service period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            intr_q   <= 1'b0;
            busy_q   <= 1'b0;
            vector_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.int_en && (|eligible)) begin
                        state_q  <= REQ;
                        intr_q   <= 1'b1;
                        vector_q <= winner;
                    end
                end
                REQ: begin
                    if (bus.int_ack) begin
                        state_q <= SERVICE;
                        intr_q  <= 1'b0;
                        busy_q  <= 1'b1;
                    end else if (!bus.int_en || !eligible[vector_q]) begin
                        state_q <= IDLE;
                        intr_q  <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (bus.int_done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    intr_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.intr    = intr_q;
    assign bus.busy    = busy_q;
    assign bus.vector  = vector_q;
    assign bus.pending = pending_q;
endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: per-cycle stimulus records with expected
// outputs queued on drive and popped/compared after the clock edge.
module tb_interrupt_controller;
    localparam int unsigned NUM_SRC = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    interrupt_controller_if #(.NUM_SRC(NUM_SRC)) bus ();

    interrupt_controller #(
        .NUM_SRC    (NUM_SRC),
        .SYNC_STAGES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        string      name;
        logic [7:0] irq;
        logic [7:0] mask;
        logic       en;
        logic       ack;
        logic       done;
        logic       intr;
        logic       vchk;
        logic [2:0] vec;
        logic [7:0] pend;
        logic       busy;
    } vec_t;

    typedef struct {
        string      name;
        logic       intr;
        logic       vchk;
        logic [2:0] vec;
        logic [7:0] pend;
        logic       busy;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic void add(string nm, logic [7:0] irq, logic [7:0] mask,
                                logic en, logic ack, logic done, logic intr,
                                logic vchk, logic [2:0] vec, logic [7:0] pend,
                                logic busy);
        vec_t v;
        v.name = nm; v.irq = irq; v.mask = mask; v.en = en; v.ack = ack;
        v.done = done; v.intr = intr; v.vchk = vchk; v.vec = vec;
        v.pend = pend; v.busy = busy;
        tbl.push_back(v);
    endfunction

    task automatic check_now(string nm, logic intr, logic vchk, logic [2:0] vec,
                             logic [7:0] pend, logic busy);
        n_tests++;
        if (bus.intr !== intr || (vchk && bus.vector !== vec) ||
            bus.pending !== pend || bus.busy !== busy) begin
            n_fail++;
            $display("FAIL %s: got intr=%b vec=%0d pend=%h busy=%b, want intr=%b vec=%0d%s pend=%h busy=%b",
                     nm, bus.intr, bus.vector, bus.pending, bus.busy,
                     intr, vec, vchk ? "" : "(any)", pend, busy);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic cyc(vec_t v);
        exp_t e;
        bus.irq      = v.irq;
        bus.mask     = v.mask;
        bus.int_en   = v.en;
        bus.int_ack  = v.ack;
        bus.int_done = v.done;
        e.name = v.name; e.intr = v.intr; e.vchk = v.vchk; e.vec = v.vec;
        e.pend = v.pend; e.busy = v.busy;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            e = sb_q.pop_front();
            check_now(e.name, e.intr, e.vchk, e.vec, e.pend, e.busy);
        end
    endtask

    task automatic row(string nm, logic [7:0] irq, logic [7:0] mask, logic en,
                       logic ack, logic done, logic intr, logic vchk,
                       logic [2:0] vec, logic [7:0] pend, logic busy);
        vec_t v;
        v.name = nm; v.irq = irq; v.mask = mask; v.en = en; v.ack = ack;
        v.done = done; v.intr = intr; v.vchk = vchk; v.vec = vec;
        v.pend = pend; v.busy = busy;
        cyc(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n        = 1'b0;
        bus.irq      = '0;
        bus.mask     = 8'hFF;
        bus.int_en   = 1'b1;
        bus.int_ack  = 1'b0;
        bus.int_done = 1'b0;

        // Tests 1-3: single source, simultaneous sources, masked source.
        add("t1_k",     8'h08, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        add("t1_k1",    8'h00, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        add("t1_k2",    8'h00, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h08, 0);
        add("t1_k3",    8'h00, 8'hFF, 1, 0, 0, 1, 1, 3, 8'h08, 0);
        add("t1_ack",   8'h00, 8'hFF, 1, 1, 0, 0, 1, 3, 8'h00, 1);
        add("t1_done",  8'h00, 8'hFF, 1, 0, 1, 0, 0, 0, 8'h00, 0);
        add("t1_idle",  8'h00, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        add("t2_k",     8'h24, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        add("t2_k1",    8'h00, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        add("t2_k2",    8'h00, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h24, 0);
        add("t2_req2",  8'h00, 8'hFF, 1, 0, 0, 1, 1, 2, 8'h24, 0);
        add("t2_ack2",  8'h00, 8'hFF, 1, 1, 0, 0, 1, 2, 8'h20, 1);
        add("t2_done2", 8'h00, 8'hFF, 1, 0, 1, 0, 0, 0, 8'h20, 0);
        add("t2_req5",  8'h00, 8'hFF, 1, 0, 0, 1, 1, 5, 8'h20, 0);
        add("t2_ack5",  8'h00, 8'hFF, 1, 1, 0, 0, 1, 5, 8'h00, 1);
        add("t2_done5", 8'h00, 8'hFF, 1, 0, 1, 0, 0, 0, 8'h00, 0);
        add("t3_k",     8'h10, 8'hEF, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        add("t3_k1",    8'h00, 8'hEF, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        add("t3_masked",8'h00, 8'hEF, 1, 0, 0, 0, 0, 0, 8'h10, 0);
        add("t3_ackign",8'h00, 8'hEF, 1, 1, 0, 0, 0, 0, 8'h10, 0);
        add("t3_dnign", 8'h00, 8'hEF, 1, 0, 1, 0, 0, 0, 8'h10, 0);
        add("t3_unmask",8'h00, 8'hFF, 1, 0, 0, 1, 1, 4, 8'h10, 0);
        add("t3_ack",   8'h00, 8'hFF, 1, 1, 0, 0, 1, 4, 8'h00, 1);
        add("t3_done",  8'h00, 8'hFF, 1, 0, 1, 0, 0, 0, 8'h00, 0);

        repeat (2) @(posedge clk);
        #1;
        check_now("reset_state", 0, 1, 0, 8'h00, 0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i]);
        end

        // Test 4: withdraw the request by dropping INT_EN, then restore.
        row("t4_k",     8'h02, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        row("t4_k1",    8'h00, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        row("t4_k2",    8'h00, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h02, 0);
        row("t4_req",   8'h00, 8'hFF, 1, 0, 0, 1, 1, 1, 8'h02, 0);
        row("t4_endrop",8'h00, 8'hFF, 0, 0, 0, 0, 0, 0, 8'h02, 0);
        row("t4_enoff", 8'h00, 8'hFF, 0, 0, 0, 0, 0, 0, 8'h02, 0);
        row("t4_enon",  8'h00, 8'hFF, 1, 0, 0, 1, 1, 1, 8'h02, 0);
        row("t4_ack",   8'h00, 8'hFF, 1, 1, 0, 0, 1, 1, 8'h00, 1);
        row("t4_done",  8'h00, 8'hFF, 1, 0, 1, 0, 0, 0, 8'h00, 0);

        // Test 5: second edge on source 6 lands on the ACK edge; ACK+DONE together.
        row("t5_k",     8'h40, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        row("t5_k1",    8'h00, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        row("t5_k2",    8'h40, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h40, 0);
        row("t5_req",   8'h00, 8'hFF, 1, 0, 0, 1, 1, 6, 8'h40, 0);
        row("t5_ackhit",8'h00, 8'hFF, 1, 1, 0, 0, 1, 6, 8'h40, 1);
        row("t5_done",  8'h00, 8'hFF, 1, 0, 1, 0, 0, 0, 8'h40, 0);
        row("t5_rereq", 8'h00, 8'hFF, 1, 0, 0, 1, 1, 6, 8'h40, 0);
        row("t5_ackdn", 8'h00, 8'hFF, 1, 1, 1, 0, 1, 6, 8'h00, 1);
        row("t5_done2", 8'h00, 8'hFF, 1, 0, 1, 0, 0, 0, 8'h00, 0);

        // Test 6: async reset while in SERVICE with PENDING=8'h81.
        row("t6_k",     8'h81, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        row("t6_k1",    8'h00, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        row("t6_k2",    8'h00, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h81, 0);
        row("t6_req",   8'h00, 8'hFF, 1, 0, 0, 1, 1, 0, 8'h81, 0);
        row("t6_ack",   8'h00, 8'hFF, 1, 1, 0, 0, 1, 0, 8'h80, 1);
        row("t6_re0",   8'h01, 8'hFF, 1, 0, 0, 0, 1, 0, 8'h80, 1);
        row("t6_re1",   8'h00, 8'hFF, 1, 0, 0, 0, 1, 0, 8'h80, 1);
        row("t6_svc81", 8'h00, 8'hFF, 1, 0, 0, 0, 1, 0, 8'h81, 1);
        rst_n = 1'b0;
        #2;
        check_now("t6_async_rst", 0, 1, 0, 8'h00, 0);

        // A line held high across reset release must register as one edge.
        bus.irq = 8'h04;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        row("t7_r1",    8'h04, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        row("t7_r2",    8'h04, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h00, 0);
        row("t7_r3",    8'h04, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h04, 0);
        row("t7_req",   8'h04, 8'hFF, 1, 0, 0, 1, 1, 2, 8'h04, 0);
        row("t7_ack",   8'h04, 8'hFF, 1, 1, 0, 0, 1, 2, 8'h00, 1);
        row("t7_done",  8'h04, 8'hFF, 1, 0, 1, 0, 0, 0, 8'h00, 0);
        row("t7_quiet", 8'h04, 8'hFF, 1, 0, 0, 0, 0, 0, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
